// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//   Hazard detection and forwarding control for a 5-stage MIPS-style pipeline.
//   Hazard descriptors decoded in D are carried through shadow copies for the
//   E, M and W stages. The unit produces the pipeline stall and every
//   forwarding-mux select combinationally. It also owns the MDU busy countdown
//   that holds MDU-class instructions in D while a mult/div is in flight.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   HSU_i_Rs/Rt       D-stage source register addresses
//   HSU_i_TuseRs/Rt   cycles from D until the source is read (15 = never)
//   HSU_i_TnewD       cycles until the result sits in a pipeline register
//   HSU_i_RegWAddr    D-stage destination register (0 when there is no result)
//   HSU_i_MDU_Usage   0 = none, 1 = stalling mult/div, 2 = mf/mt hi/lo
//   HSU_i_IsDiv       selects DIV_LAT vs MULT_LAT for a stalling MDU op
//   HSU_i_Flush       kills the instructions in E and M
//   HSU_o_Stall       freeze PC and IF/ID, bubble into ID/EX
//   HSU_o_FwdD_Rs/Rt  D operand source: 0 regfile, 1 E, 2 M, 3 W
//   HSU_o_FwdE_Rs/Rt  E operand source: 0 ID/EX, 2 M, 3 W
//   HSU_o_FwdM_Rt     M store data source: 0 EX/MEM, 1 W
//   HSU_o_MDU_Busy    MDU busy counter is nonzero
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter logic [5:0] MULT_LAT = 6'd5,
    parameter logic [5:0] DIV_LAT  = 6'd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] HSU_i_Rs,
    input  logic [4:0] HSU_i_Rt,
    input  logic [3:0] HSU_i_TuseRs,
    input  logic [3:0] HSU_i_TuseRt,
    input  logic [3:0] HSU_i_TnewD,
    input  logic [4:0] HSU_i_RegWAddr,
    input  logic [3:0] HSU_i_MDU_Usage,
    input  logic       HSU_i_IsDiv,
    input  logic       HSU_i_Flush,
    output logic       HSU_o_Stall,
    output logic [1:0] HSU_o_FwdD_Rs,
    output logic [1:0] HSU_o_FwdD_Rt,
    output logic [1:0] HSU_o_FwdE_Rs,
    output logic [1:0] HSU_o_FwdE_Rt,
    output logic       HSU_o_FwdM_Rt,
    output logic       HSU_o_MDU_Busy
);

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] addr;
        logic [3:0] tnew;
        logic [3:0] mdu;
    } entry_t;

    localparam entry_t BUBBLE = '0;

    entry_t     e_q, m_q, w_q;
    entry_t     e_d, m_d, w_d;
    entry_t     d_entry_s;
    logic [5:0] busy_q, busy_d;
    logic       rs_live_s, rt_live_s;
    logic       data_stall_s, mdu_stall_s, stall_s, advance_s;

    // Remaining-cycle count after one stage advance, floored at zero.
    function automatic logic [3:0] dec_sat(input logic [3:0] t);
        return (t == 4'd0) ? 4'd0 : (t - 4'd1);
    endfunction

    // A stage produces the source register; $0 never matches.
    function automatic logic hit(input logic [4:0] addr, input logic [4:0] src);
        return (addr != 5'd0) && (addr == src);
    endfunction

    // D-stage forward select: nearest ready producer, E > M > W.
    function automatic logic [1:0] fwd_d_sel(input logic [4:0] src, input logic live,
                                             input entry_t e, input entry_t m, input entry_t w);
        logic [1:0] sel;
        if (live && hit(e.addr, src) && (e.tnew == 4'd0)) begin
            sel = 2'd1;
        end else if (live && hit(m.addr, src) && (m.tnew == 4'd0)) begin
            sel = 2'd2;
        end else if (live && hit(w.addr, src) && (w.tnew == 4'd0)) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // E-stage forward select: M > W, against the E entry's own source.
    function automatic logic [1:0] fwd_e_sel(input logic [4:0] src, input entry_t m, input entry_t w);
        logic [1:0] sel;
        if (hit(m.addr, src) && (m.tnew == 4'd0)) begin
            sel = 2'd2;
        end else if (hit(w.addr, src) && (w.tnew == 4'd0)) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Stall decision: a producer in E/M not ready in time, or MDU occupied.
    always_comb begin
        rs_live_s    = (HSU_i_TuseRs != 4'd15);
        rt_live_s    = (HSU_i_TuseRt != 4'd15);
        data_stall_s = (rs_live_s && hit(e_q.addr, HSU_i_Rs) && (e_q.tnew > HSU_i_TuseRs))
                     | (rs_live_s && hit(m_q.addr, HSU_i_Rs) && (m_q.tnew > HSU_i_TuseRs))
                     | (rt_live_s && hit(e_q.addr, HSU_i_Rt) && (e_q.tnew > HSU_i_TuseRt))
                     | (rt_live_s && hit(m_q.addr, HSU_i_Rt) && (m_q.tnew > HSU_i_TuseRt));
        mdu_stall_s  = (HSU_i_MDU_Usage != 4'd0) && ((busy_q != 6'd0) || (e_q.mdu == 4'd1));
        stall_s      = data_stall_s | mdu_stall_s;
        advance_s    = !stall_s && !HSU_i_Flush;
    end

    // Shadow pipeline and MDU counter next state.
    always_comb begin
        d_entry_s.rs   = HSU_i_Rs;
        d_entry_s.rt   = HSU_i_Rt;
        d_entry_s.addr = (HSU_i_TnewD == 4'd0) ? 5'd0 : HSU_i_RegWAddr;
        d_entry_s.tnew = dec_sat(HSU_i_TnewD);
        d_entry_s.mdu  = HSU_i_MDU_Usage;

        w_d      = m_q;
        w_d.tnew = dec_sat(m_q.tnew);
        m_d      = e_q;
        m_d.tnew = dec_sat(e_q.tnew);
        e_d      = d_entry_s;
        // Flush kills E and M; W still retires the old M entry.
        if (HSU_i_Flush) begin
            e_d = BUBBLE;
            m_d = BUBBLE;
        end else if (stall_s) begin
            e_d = BUBBLE;
        end else begin
            e_d = d_entry_s;
        end

        busy_d = busy_q;
        if (advance_s && (HSU_i_MDU_Usage == 4'd1)) begin
            busy_d = HSU_i_IsDiv ? DIV_LAT : MULT_LAT;
        end else if (busy_q != 6'd0) begin
            busy_d = busy_q - 6'd1;
        end else begin
            busy_d = 6'd0;
        end
    end

    // State registers for the shadow entries and the MDU countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q    <= BUBBLE;
            m_q    <= BUBBLE;
            w_q    <= BUBBLE;
            busy_q <= 6'd0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            busy_q <= busy_d;
        end
    end

    assign HSU_o_Stall    = stall_s;
    assign HSU_o_FwdD_Rs  = fwd_d_sel(HSU_i_Rs, rs_live_s, e_q, m_q, w_q);
    assign HSU_o_FwdD_Rt  = fwd_d_sel(HSU_i_Rt, rt_live_s, e_q, m_q, w_q);
    assign HSU_o_FwdE_Rs  = fwd_e_sel(e_q.rs, m_q, w_q);
    assign HSU_o_FwdE_Rt  = fwd_e_sel(e_q.rt, m_q, w_q);
    assign HSU_o_FwdM_Rt  = hit(w_q.addr, m_q.rt) && (w_q.tnew == 4'd0);
    assign HSU_o_MDU_Busy = (busy_q != 6'd0);

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed pipeline scenarios plus randomized
// instruction streams, all outputs compared against a reference model that
// tracks in-flight instructions by their issue cycle.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs_i = 5'd0, rt_i = 5'd0, waddr_i = 5'd0;
    logic [3:0] tuse_rs_i = 4'd15, tuse_rt_i = 4'd15, tnewd_i = 4'd0, mdu_i = 4'd0;
    logic       isdiv_i = 1'b0, flush_i = 1'b0;
    logic       stall_o, fwdm_rt_o, busy_o;
    logic [1:0] fwdd_rs_o, fwdd_rt_o, fwde_rs_o, fwde_rt_o;

    int total = 0;
    int bad   = 0;

    hazard_stall_unit dut (
        .clk(clk), .rst_n(rst_n),
        .HSU_i_Rs(rs_i), .HSU_i_Rt(rt_i),
        .HSU_i_TuseRs(tuse_rs_i), .HSU_i_TuseRt(tuse_rt_i),
        .HSU_i_TnewD(tnewd_i), .HSU_i_RegWAddr(waddr_i),
        .HSU_i_MDU_Usage(mdu_i), .HSU_i_IsDiv(isdiv_i), .HSU_i_Flush(flush_i),
        .HSU_o_Stall(stall_o),
        .HSU_o_FwdD_Rs(fwdd_rs_o), .HSU_o_FwdD_Rt(fwdd_rt_o),
        .HSU_o_FwdE_Rs(fwde_rs_o), .HSU_o_FwdE_Rt(fwde_rt_o),
        .HSU_o_FwdM_Rt(fwdm_rt_o), .HSU_o_MDU_Busy(busy_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each in-flight instruction remembers the cycle it sat in D; its
    // remaining latency is TnewD minus the cycles elapsed since then.
    typedef struct {
        bit valid;
        int rs, rt, addr, tnewd, dcyc, mdu;
    } rec_t;

    rec_t pipe [1:3];
    int   cyc = 0;
    int   busy_until = -100;
    bit   m_stall;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic rec_t bubble();
        rec_t r;
        r.valid = 0; r.rs = 0; r.rt = 0; r.addr = 0; r.tnewd = 0; r.dcyc = 0; r.mdu = 0;
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 1; k <= 3; k++) pipe[k] = bubble();
        busy_until = -100;
    endtask

    function automatic int tnew_at(int k);
        int t;
        t = pipe[k].tnewd - (cyc - pipe[k].dcyc);
        return (pipe[k].valid && t > 0) ? t : 0;
    endfunction

    function automatic bit hits(int k, int src);
        return pipe[k].valid && pipe[k].addr != 0 && pipe[k].addr == src;
    endfunction

    function automatic bit d_stall(int src, int tuse);
        if (tuse == 15) return 0;
        for (int k = 1; k <= 2; k++)
            if (hits(k, src) && tnew_at(k) > tuse) return 1;
        return 0;
    endfunction

    function automatic int fwd_from(int src, int first);
        for (int k = first; k <= 3; k++)
            if (hits(k, src) && tnew_at(k) == 0) return (first == 1) ? k : k;
        return 0;
    endfunction

    // Compare every DUT output against the model for the current cycle.
    task automatic eval();
        bit busy, mstall;
        int fd_rs, fd_rt;
        #1;
        busy   = (cyc <= busy_until);
        mstall = (mdu_i != 0) && (busy || (pipe[1].valid && pipe[1].mdu == 1));
        m_stall = d_stall(rs_i, tuse_rs_i) || d_stall(rt_i, tuse_rt_i) || mstall;
        fd_rs = (tuse_rs_i == 15) ? 0 : fwd_from(rs_i, 1);
        fd_rt = (tuse_rt_i == 15) ? 0 : fwd_from(rt_i, 1);
        check_val("stall",   {7'd0, stall_o}, {7'd0, m_stall});
        check_val("busy",    {7'd0, busy_o},  {7'd0, busy});
        check_val("fwdD_rs", {6'd0, fwdd_rs_o}, 8'(fd_rs));
        check_val("fwdD_rt", {6'd0, fwdd_rt_o}, 8'(fd_rt));
        check_val("fwdE_rs", {6'd0, fwde_rs_o}, 8'(pipe[1].valid ? fwd_from(pipe[1].rs, 2) : 0));
        check_val("fwdE_rt", {6'd0, fwde_rt_o}, 8'(pipe[1].valid ? fwd_from(pipe[1].rt, 2) : 0));
        check_val("fwdM_rt", {7'd0, fwdm_rt_o},
                  {7'd0, (pipe[2].valid && hits(3, pipe[2].rt) && tnew_at(3) == 0)});
    endtask

    // Advance the model by one clock and let the DUT take the same edge.
    task automatic tick();
        rec_t nd;
        nd.valid = 1; nd.rs = rs_i; nd.rt = rt_i;
        nd.addr = (tnewd_i == 0) ? 0 : int'(waddr_i);
        nd.tnewd = tnewd_i; nd.dcyc = cyc; nd.mdu = mdu_i;
        pipe[3] = pipe[2];
        pipe[2] = flush_i ? bubble() : pipe[1];
        pipe[1] = (flush_i || m_stall) ? bubble() : nd;
        if (!flush_i && !m_stall && mdu_i == 1) busy_until = cyc + (isdiv_i ? 10 : 5);
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_d(input int rs, input int rt, input int trs, input int trt,
                         input int tnew, input int wa, input int mdu, input bit dv, input bit fl);
        rs_i = 5'(rs); rt_i = 5'(rt); tuse_rs_i = 4'(trs); tuse_rt_i = 4'(trt);
        tnewd_i = 4'(tnew); waddr_i = 5'(wa); mdu_i = 4'(mdu); isdiv_i = dv; flush_i = fl;
    endtask

    task automatic nop();
        set_d(0, 0, 15, 15, 0, 0, 0, 0, 0);
    endtask

    // Reset from a negedge: hold, check the reset outputs, release.
    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        eval();
        check_val("rst_stall", {7'd0, stall_o}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        model_clear();
        nop();
        @(negedge clk);
        do_reset();

        // 1: lw $8 then beq $8,$0 in D -> two stall cycles, then forward from W.
        set_d(0, 0, 15, 15, 3, 8, 0, 0, 0); eval(); tick();
        set_d(8, 0, 0, 0, 0, 0, 0, 0, 0);
        eval(); check_val("t1_stall_a", {7'd0, stall_o}, 8'd1); tick();
        eval(); check_val("t1_stall_b", {7'd0, stall_o}, 8'd1); tick();
        eval(); check_val("t1_go", {7'd0, stall_o}, 8'd0);
        check_val("t1_fwdD", {6'd0, fwdd_rs_o}, 8'd3); tick();

        // 2: two producers of $9 then a consumer in E: M beats W.
        do_reset();
        set_d(1, 2, 0, 0, 1, 9, 0, 0, 0); eval(); tick();
        set_d(1, 2, 0, 0, 1, 9, 0, 0, 0); eval(); tick();
        set_d(9, 0, 1, 15, 1, 10, 0, 0, 0); eval(); tick();
        nop(); eval(); check_val("t2_fwdE", {6'd0, fwde_rs_o}, 8'd2); tick();

        // 3: jal in E, jr $31 in D -> forward from E with no stall.
        do_reset();
        set_d(0, 0, 15, 15, 1, 31, 0, 0, 0); eval(); tick();
        set_d(31, 0, 0, 15, 0, 0, 0, 0, 0); eval();
        check_val("t3_stall", {7'd0, stall_o}, 8'd0);
        check_val("t3_fwdD", {6'd0, fwdd_rs_o}, 8'd1); tick();

        // 4: div issued, mfhi waits exactly DIV_LAT cycles.
        do_reset();
        set_d(4, 5, 1, 1, 0, 0, 1, 1, 0); eval(); tick();
        set_d(0, 0, 15, 15, 1, 6, 2, 0, 0);
        for (int i = 0; i < 10; i++) begin
            eval(); check_val("t4_busy_stall", {6'd0, stall_o, busy_o}, 8'd3); tick();
        end
        eval(); check_val("t4_release", {6'd0, stall_o, busy_o}, 8'd0); tick();

        // 5: flush kills lw $8 in E; add $8 next cycle neither stalls nor forwards.
        do_reset();
        set_d(0, 0, 15, 15, 3, 8, 0, 0, 0); eval(); tick();
        set_d(8, 8, 1, 1, 1, 7, 0, 0, 1); eval(); tick();
        set_d(8, 8, 1, 1, 1, 7, 0, 0, 0); eval();
        check_val("t5_stall", {7'd0, stall_o}, 8'd0);
        check_val("t5_fwd", {4'd0, fwdd_rs_o, fwdd_rt_o}, 8'd0); tick();

        // 6: lw $0 never stalls or forwards; async reset kills a mult in flight.
        do_reset();
        set_d(0, 0, 15, 15, 3, 0, 0, 0, 0); eval(); tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); eval();
        check_val("t6_zero", {3'd0, stall_o, fwdd_rs_o, fwdd_rt_o}, 8'd0); tick();
        set_d(1, 2, 1, 1, 0, 0, 1, 0, 0); eval(); tick();
        set_d(0, 0, 15, 15, 1, 3, 2, 0, 0); eval();
        check_val("t6_busy_pre", {7'd0, busy_o}, 8'd1);
        #2 rst_n = 1'b0;
        #1 check_val("t6_async_busy", {6'd0, busy_o, stall_o}, 8'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        eval(); check_val("t6_after_rel", {7'd0, busy_o}, 8'd0); tick();

        // Randomized instruction stream over a small register set.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int tn, tr, tt, md;
            tn = $urandom_range(0, 3);
            r  = $urandom_range(0, 3); tr = (r == 3) ? 15 : r;
            r  = $urandom_range(0, 3); tt = (r == 3) ? 15 : r;
            r  = $urandom_range(0, 19); md = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            set_d($urandom_range(0, 3), $urandom_range(0, 3), tr, tt, tn,
                  (tn == 0) ? 0 : $urandom_range(0, 3), md, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 29) == 0));
            eval();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
